riscv_issue: RTL

//  Upstream issue stage for the riscv instruction pipeline. It accepts raw 32-bit RISC-V

---
 rtl/riscv_issue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/riscv_issue.sv
// Issue stage: buffers raw RV32 instruction words in a circular queue and issues one per cycle,
// credit-limited by MAX_INFLIGHT. Define RISCV_ISSUE_ILLEGAL_CHECK_EN to drop heads with opcode[1:0] != 2'b11.
module riscv_issue #(
  parameter int unsigned REG_WIDTH    = 5,
  parameter int unsigned OP_WIDTH     = 7,
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [INSTR_WIDTH-1:0]            instr_in,
  input  logic                              instr_valid,
  output logic                              instr_ready,
  input  logic                              flush,
  input  logic                              ack_in,
  output logic                              valid,
  output logic [REG_WIDTH-1:0]              rs0,
  output logic [REG_WIDTH-1:0]              rs1,
  output logic [REG_WIDTH-1:0]              rd,
  output logic [OP_WIDTH-1:0]               opcode,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              illegal
);
  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  logic [INSTR_WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [IW-1:0]          inflight_q, inflight_d;
  state_t                 state_q, state_d;
  logic                   ready_en_q;
  logic                   valid_q, valid_d, illegal_q, illegal_d;
  logic [REG_WIDTH-1:0]   rs0_q, rs0_d, rs1_q, rs1_d, rd_q, rd_d;
  logic [OP_WIDTH-1:0]    opcode_q, opcode_d;
  logic [INSTR_WIDTH-1:0] head;
  logic                   push, issue, drop, legal, ack_eff;
  logic                   unused_bits;

  assign unused_bits = ^{head[INSTR_WIDTH-1:25], head[14:12]};

  always_comb begin
    instr_ready = ready_en_q && !flush && (count_q < CW'(QUEUE_DEPTH));
    push        = instr_valid && instr_ready;
    head        = mem_q[rd_ptr_q];
`ifdef RISCV_ISSUE_ILLEGAL_CHECK_EN
    legal       = (head[1:0] == 2'b11);
    drop        = (state_q != IDLE) && !flush && !legal;
`else
    legal       = 1'b1;
    drop        = 1'b0;
`endif
    // state_q mirrors the current count/inflight, so ISSUE already means non-empty with credit
    issue       = (state_q == ISSUE) && !flush && legal;
    ack_eff     = ack_in && (inflight_q != '0);

    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(issue || drop);
    count_d     = count_q + CW'(push) - CW'(issue || drop);
    inflight_d  = inflight_q + IW'(issue) - IW'(ack_eff);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end

    if (flush || count_d == '0)                state_d = IDLE;
    else if (inflight_d == IW'(MAX_INFLIGHT))  state_d = STALL;
    else                                       state_d = ISSUE;

    valid_d   = issue;
    illegal_d = drop;
    rs0_d     = rs0_q;
    rs1_d     = rs1_q;
    rd_d      = rd_q;
    opcode_d  = opcode_q;
    if (issue) begin
      opcode_d = head[6:0];
      rs0_d    = head[19:15];
      rs1_d    = head[24:20];
      rd_d     = head[11:7];
      if (head[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111}) begin
        rs0_d = '0;
        rs1_d = '0;
      end
      if (head[6:0] inside {7'b0100011, 7'b1100011}) rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      rs0_q      <= '0;
      rs1_q      <= '0;
      rd_q       <= '0;
      opcode_q   <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= instr_in;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      ready_en_q <= 1'b1;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      rs0_q      <= rs0_d;
      rs1_q      <= rs1_d;
      rd_q       <= rd_d;
      opcode_q   <= opcode_d;
    end
  end

  assign valid    = valid_q;
  assign illegal  = illegal_q;
  assign rs0      = rs0_q;
  assign rs1      = rs1_q;
  assign rd       = rd_q;
  assign opcode   = opcode_q;
  assign inflight = inflight_q;
endmodule
